timeout_arbiter: RTL and testbench
==================================

// Module: timeout_arbiter
// PURPOSE
//   Shares one saturating down-counter (stops at 0) among NUM_REQ requesters.
//   Each requester asks for a timeout of req_len ticks. The block grants requesters
//   round-robin, loads the counter and decrements it on each tick. When the counter
//   reaches 0 it pulses that requester's done bit. Sits between protocol FSMs and
//   the shared timer, so there is one timer per block, not one per client.
// PARAMETERS
//   NUM_REQ  4  number of requesters (>=2)
//   WIDTH    8  counter / timeout length width in bits
// PORTS
//   clk        in   1                clock
//   reset_n    in   1                async active-low reset
//   req        in   NUM_REQ          level request per requester; hold until done
//   req_len    in   NUM_REQ*WIDTH    timeout length; requester i uses bits [i*WIDTH +: WIDTH]
//   tick       in   1                decrement enable (prescaler strobe)
//   grant      out  NUM_REQ          one-hot owner of the counter, 0 when idle
//   done       out  NUM_REQ          one-cycle pulse to owner on expiry
//   busy       out  1                counter owned (state != IDLE)
//   remaining  out  WIDTH            current counter value
// BEHAVIOUR
//   - Reset (async, reset_n=0):
//     - state=IDLE; grant, done, busy and remaining are all 0.
//     - RR pointer = 0, so index 0 has top priority first.
//   - FSM states: IDLE -> LOAD -> COUNT -> DONE -> IDLE. All outputs are registered.
//   - IDLE:
//     - If req != 0, pick the first set bit at or after the RR pointer (wrapping).
//     - Latch that index as owner and go to LOAD.
//   - LOAD:
//     - grant[owner]=1 and busy=1.
//     - Load the counter with req_len[owner], sampled this cycle.
//     - If req_len[owner]==0, go to DONE. Otherwise go to COUNT.
//   - COUNT:
//     - remaining decrements by 1 on each cycle with tick=1 and remaining!=0.
//     - It never wraps below 0.
//     - When remaining==0, go to DONE.
//   - DONE:
//     - done[owner]=1 for exactly this cycle; grant is still held.
//     - RR pointer becomes (owner+1) mod NUM_REQ. Go to IDLE; grant is 0 next cycle.
//   - Latency, with req seen in IDLE at cycle t and tick held at 1:
//     - grant at t+1; remaining=L at t+2.
//     - done at t+L+3 for L>=1; done at t+2 for L=0.
//     - A new arbitration may start in the IDLE cycle right after DONE.
//   - Cancel: if req[owner] drops in LOAD or COUNT, go to IDLE next cycle.
//     - No done pulse; remaining is cleared to 0.
//     - RR pointer advances exactly as it does after DONE.
//   - Request changes: changes to req_len[owner] after LOAD are ignored.
//     Non-owner req bits are ignored until the next IDLE.
//   - Tick timing: tick in IDLE or LOAD has no effect. tick in DONE is ignored.
//   - Reset mid-operation: returns to the reset state at once. No done is emitted.
//   - Invariants:
//     - grant is always one-hot or zero; done is a subset of grant.
//     - At most one done bit is set per cycle.
// TESTING
//   1. req=0001, len0=5, tick=1 -> grant=0001 at t+1; remaining 5,4..0; done=0001 at t+8, single cycle.
//   2. req=0010, len1=0 -> grant at t+1, done=0010 at t+2, COUNT never entered.
//   3. req=1111 held, all len=2, tick=1 -> grants in order 0,1,2,3,0; no gaps beyond 1 IDLE cycle each.
//   4. len=3, tick pulsed every 3rd cycle -> remaining decrements only on tick cycles; done 1 cycle after remaining hits 0.
//   5. Owner drops req while remaining=4 -> IDLE next cycle, done stays 0, next pending requester granted.
//   6. reset_n low while remaining=7 -> outputs 0 immediately; after release, req=0100 is granted (pointer back to 0, next set bit).

Source files
------------

// File: rtl/timeout_arbiter.sv
// Round-robin arbiter that lends one saturating down-counter to NUM_REQ requesters.
// The owner's req_len is loaded, counted down on tick, and a one-cycle done pulse marks expiry.
module timeout_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_len,
  input  logic                     tick,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic [WIDTH-1:0]         remaining
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StCount,
    StDone
  } state_e;

  state_e             state_q, state_d;
  logic [IdxW-1:0]    owner_q, owner_d;
  logic [IdxW-1:0]    ptr_q, ptr_d;
  logic [WIDTH-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               busy_q, busy_d;

  logic [IdxW-1:0]    pick;
  logic               pick_valid;
  logic [IdxW-1:0]    ptr_after;
  logic [NUM_REQ-1:0] owner_oh;
  logic               owner_req;
  logic [WIDTH-1:0]   owner_len;

  function automatic logic [IdxW-1:0] wrap_add(logic [IdxW-1:0] base, int unsigned k);
    int unsigned sum;
    sum = int'(base) + k;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return IdxW'(sum);
  endfunction

  function automatic logic [NUM_REQ-1:0] to_onehot(logic [IdxW-1:0] idx);
    logic [NUM_REQ-1:0] oh;
    oh = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (idx == IdxW'(i)) oh[i] = 1'b1;
    end
    return oh;
  endfunction

  // First requester at or after the pointer, wrapping around.
  always_comb begin
    pick       = ptr_q;
    pick_valid = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!pick_valid && |(req & to_onehot(wrap_add(ptr_q, k)))) begin
        pick_valid = 1'b1;
        pick       = wrap_add(ptr_q, k);
      end
    end
  end

  always_comb begin
    owner_len = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (owner_q == IdxW'(i)) owner_len = req_len[i*WIDTH +: WIDTH];
    end
  end

  assign owner_oh  = to_onehot(owner_q);
  assign owner_req = |(req & owner_oh);
  assign ptr_after = (owner_q == LastIdx) ? '0 : owner_q + 1'b1;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          owner_d = pick;
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (!owner_req) begin
          state_d = StIdle;
          cnt_d   = '0;
          ptr_d   = ptr_after;
        end else begin
          cnt_d   = owner_len;
          state_d = (owner_len == '0) ? StDone : StCount;
        end
      end
      StCount: begin
        // A withdrawn request wins over expiry: cancelled timers never pulse done.
        if (!owner_req) begin
          state_d = StIdle;
          cnt_d   = '0;
          ptr_d   = ptr_after;
        end else if (cnt_q == '0) begin
          state_d = StDone;
        end else if (tick) begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
        ptr_d   = ptr_after;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are computed from the next state so that they come straight out of flops.
  always_comb begin
    grant_d = '0;
    done_d  = '0;
    busy_d  = (state_d != StIdle);
    if (busy_d) grant_d = to_onehot(owner_d);
    if (state_d == StDone) done_d = to_onehot(owner_d);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign remaining = cnt_q;

  grant_onehot0_a: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(grant));
  done_onehot0_a:  assert property (@(posedge clk) disable iff (!reset_n) $onehot0(done));
  done_in_grant_a: assert property (@(posedge clk) disable iff (!reset_n) (done & ~grant) == '0);

endmodule

// File: tb/tb_timeout_arbiter.sv
// Randomized plus directed bench for timeout_arbiter: a transaction-level model
// predicts every cycle's outputs into a scoreboard that a separate monitor drains.
module tb_timeout_arbiter;
  localparam int unsigned N = 4;
  localparam int unsigned W = 8;

  logic         clk     = 1'b0;
  logic         reset_n = 1'b0;
  logic [N-1:0] req     = '0;
  logic [N*W-1:0] req_len = '0;
  logic         tick    = 1'b0;
  logic [N-1:0] grant;
  logic [N-1:0] done;
  logic         busy;
  logic [W-1:0] remaining;

  timeout_arbiter #(
    .NUM_REQ(N),
    .WIDTH  (W)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (req),
    .req_len  (req_len),
    .tick     (tick),
    .grant    (grant),
    .done     (done),
    .busy     (busy),
    .remaining(remaining)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] grant;
    logic [N-1:0] done;
    logic         busy;
    logic [W-1:0] rem;
  } out_t;

  out_t exp_q[$];
  int   done_owner_q[$];
  int   grant_log[$];
  int   done_log[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   edge_n  = 0;
  int   grant_edge = -1;
  int   done_edge  = -1;
  int   rem_zero_edge = -1;
  int   t_edge;
  logic [N-1:0] prev_grant = '0;
  logic [W-1:0] prev_rem   = '0;

  // Reference model: owner index (-1 = free), counter (-1 = not yet loaded), expiry flag.
  int m_own = -1;
  int m_rem = -1;
  int m_ptr = 0;
  bit m_fin = 1'b0;
  bit m_done_now = 1'b0;

  task automatic check(input string nm, input longint act, input longint expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", nm, act, expv, edge_n);
    end
  endtask

  task automatic set_len(input int i, input int v);
    req_len[i*W +: W] = W'(v);
  endtask

  function automatic int oh2idx(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = N - 1; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  // Predict the outputs after the coming clock edge from the inputs now applied.
  task automatic model_step();
    out_t e;
    bit   found;
    e = '0;
    m_done_now = 1'b0;
    if (!reset_n) begin
      m_own = -1; m_rem = -1; m_ptr = 0; m_fin = 1'b0;
    end else if (m_own < 0) begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (!found && req[(m_ptr + k) % N]) begin
          found = 1'b1;
          m_own = (m_ptr + k) % N;
        end
      end
      m_rem = -1;
      m_fin = 1'b0;
    end else if (m_fin) begin
      m_ptr = (m_own + 1) % N; m_own = -1; m_fin = 1'b0;
    end else if (!req[m_own]) begin
      m_ptr = (m_own + 1) % N; m_own = -1;
    end else if (m_rem < 0) begin
      m_rem = int'(req_len[m_own*W +: W]);
      if (m_rem == 0) m_fin = 1'b1;
    end else if (m_rem == 0) begin
      m_fin = 1'b1;
    end else if (tick) begin
      m_rem--;
    end
    if (m_own >= 0) begin
      e.grant = N'(1) << m_own;
      e.busy  = 1'b1;
      e.rem   = (m_rem < 0) ? '0 : W'(m_rem);
      if (m_fin) begin
        e.done = N'(1) << m_own;
        done_owner_q.push_back(m_own);
        m_done_now = 1'b1;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    model_step();
    @(negedge clk);
  endtask

  task automatic run_until_done(input int maxc, input string nm);
    int c;
    c = 0;
    do begin
      cyc();
      c++;
    end while (!m_done_now && c < maxc);
    if (!m_done_now) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: no done within %0d cycles", nm, maxc);
    end
  endtask

  task automatic apply_reset(input string nm);
    reset_n = 1'b0;
    #1;
    check(nm, longint'({grant, done, busy, remaining}), 0);
    model_step();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  out_t mon_a;
  out_t mon_e;
  int   mon_o;
  always @(posedge clk) begin
    edge_n++;
    #1;
    mon_a = {grant, done, busy, remaining};
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("outputs", longint'(mon_a), longint'(mon_e));
    end
    check("grant_onehot0", longint'($onehot0(grant)), 1);
    check("done_in_grant", longint'(done & ~grant), 0);
    if (done != '0) begin
      done_edge = edge_n;
      done_log.push_back(edge_n);
      if (done_owner_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got %b, expected no done", done);
      end else begin
        mon_o = done_owner_q.pop_front();
        check("done_owner", longint'(done), longint'(1) << mon_o);
      end
    end
    if (grant != '0 && grant != prev_grant) begin
      grant_edge = edge_n;
      grant_log.push_back(oh2idx(grant));
    end
    if (busy && remaining == '0 && prev_rem != '0) rem_zero_edge = edge_n;
    prev_grant = grant;
    prev_rem   = remaining;
  end

  initial begin
    repeat (3) cyc();
    check("reset_outputs", longint'({grant, done, busy, remaining}), 0);
    reset_n = 1'b1;

    // 1: single request, length 5
    set_len(0, 5);
    tick = 1'b1;
    req = 4'b0001;
    t_edge = edge_n + 1;
    run_until_done(30, "t1");
    req = '0;
    repeat (2) cyc();
    check("t1_grant_latency", grant_edge - t_edge, 0);
    check("t1_done_latency", done_edge - t_edge, 7);

    // 2: zero length expires straight from load
    set_len(1, 0);
    req = 4'b0010;
    t_edge = edge_n + 1;
    run_until_done(10, "t2");
    req = '0;
    repeat (2) cyc();
    check("t2_grant_latency", grant_edge - t_edge, 0);
    check("t2_done_latency", done_edge - t_edge, 1);

    // 3: all requesting, round-robin order from a fresh pointer
    apply_reset("t3_reset_async");
    for (int i = 0; i < N; i++) set_len(i, 2);
    grant_log.delete();
    done_log.delete();
    req = 4'b1111;
    repeat (5) run_until_done(20, "t3");
    req = '0;
    repeat (2) cyc();
    check("t3_grant_count", grant_log.size(), 5);
    if (grant_log.size() == 5) begin
      for (int i = 0; i < 5; i++) check("t3_grant_order", grant_log[i], i % N);
      for (int i = 1; i < 5; i++) check("t3_done_spacing", done_log[i] - done_log[i-1], 6);
    end

    // 4: sparse ticks
    set_len(1, 3);
    req = 4'b0010;
    rem_zero_edge = -1;
    for (int k = 0; k < 60; k++) begin
      tick = (k % 3 == 2);
      cyc();
      if (m_done_now) break;
    end
    if (!m_done_now) begin
      n_tests++;
      n_fail++;
      $display("FAIL t4_timeout: no done within 60 cycles");
    end
    req = '0;
    tick = 1'b1;
    repeat (2) cyc();
    check("t4_done_after_zero", done_edge - rem_zero_edge, 1);

    // 5: owner withdraws at remaining=4, next pending requester takes over
    set_len(2, 9);
    set_len(1, 1);
    req = 4'b0110;
    for (int k = 0; k < 40; k++) begin
      cyc();
      if (m_own == 2 && m_rem == 4) break;
    end
    req = 4'b0010;
    cyc();
    check("t5_cancel_busy", longint'(busy), 0);
    check("t5_cancel_done", longint'(done), 0);
    check("t5_cancel_remaining", longint'(remaining), 0);
    run_until_done(20, "t5");
    req = '0;
    repeat (2) cyc();
    check("t5_next_owner", grant_log[$], 1);

    // 6: reset mid-count, then fresh arbitration
    set_len(0, 9);
    req = 4'b0001;
    for (int k = 0; k < 40; k++) begin
      cyc();
      if (m_own == 0 && m_rem == 7) break;
    end
    check("t6_remaining_before_reset", longint'(remaining), 7);
    apply_reset("t6_reset_async");
    req = 4'b0100;
    grant_log.delete();
    run_until_done(30, "t6");
    req = '0;
    repeat (2) cyc();
    check("t6_grant_count", grant_log.size(), 1);
    if (grant_log.size() > 0) check("t6_grant_owner", grant_log[0], 2);

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      tick = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0)
        set_len(int'($urandom_range(0, N - 1)),
                ($urandom_range(0, 31) == 0) ? int'($urandom_range(0, 255))
                                             : int'($urandom_range(0, 6)));
      for (int i = 0; i < N; i++) begin
        if (i == m_own) begin
          if (!m_fin && $urandom_range(0, 39) == 0) req[i] = 1'b0;
          else if (m_fin && $urandom_range(0, 1) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 7) == 0) begin
          req[i] = ~req[i];
        end
      end
      if ($urandom_range(0, 599) == 0) apply_reset("rand_reset_async");
      else cyc();
    end
    req = '0;
    repeat (4) cyc();
    check("scoreboard_drained", exp_q.size(), 0);
    check("done_queue_drained", done_owner_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
